// File: rtl/seq_rec_pkg.sv
// Shared encodings for the sequence-recorder trigger controller.
package seq_rec_pkg;

  typedef enum logic [1:0] {
    TRIG_SW       = 2'd0,
    TRIG_EXT_RISE = 2'd1,
    TRIG_EXT_FALL = 2'd2,
    TRIG_PATTERN  = 2'd3
  } trig_src_e;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_FIRE    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ARMED   = ST_ARMED,
    S_DELAY   = ST_DELAY,
    S_FIRE    = ST_FIRE,
    S_HOLDOFF = ST_HOLDOFF
  } state_e;

endpackage

// File: rtl/seq_rec_trig_ctrl_if.sv
// Control/status bundle between register file, trigger controller and recorder.
interface seq_rec_trig_ctrl_if #(
  parameter int IN_BITS  = 8,
  parameter int CNT_BITS = 16
) ();
  logic                ARM;
  logic                ABORT;
  logic                SW_TRIG;
  logic                EXT_TRIG;
  logic [1:0]          TRIG_SRC;
  logic [IN_BITS-1:0]  PAT_IN;
  logic [IN_BITS-1:0]  PAT_VALUE;
  logic [IN_BITS-1:0]  PAT_MASK;
  logic [CNT_BITS-1:0] DELAY;
  logic [CNT_BITS-1:0] HOLDOFF;
  logic [CNT_BITS-1:0] REPEAT;
  logic                SEQ_EXT_START;
  logic                BUSY;
  logic                DONE;
  logic                MISSED;
  logic [CNT_BITS-1:0] TRIG_COUNT;

  modport master (
    output ARM, ABORT, SW_TRIG, EXT_TRIG, TRIG_SRC, PAT_IN, PAT_VALUE, PAT_MASK,
           DELAY, HOLDOFF, REPEAT,
    input  SEQ_EXT_START, BUSY, DONE, MISSED, TRIG_COUNT
  );

  modport slave (
    input  ARM, ABORT, SW_TRIG, EXT_TRIG, TRIG_SRC, PAT_IN, PAT_VALUE, PAT_MASK,
           DELAY, HOLDOFF, REPEAT,
    output SEQ_EXT_START, BUSY, DONE, MISSED, TRIG_COUNT
  );
endinterface

// File: rtl/seq_rec_trig_detect.sv
// Trigger source mux with edge and pattern-match history; emits a one-cycle event.
module seq_rec_trig_detect
  import seq_rec_pkg::*;
#(
  parameter int IN_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_match_i,
  input  trig_src_e          trig_src_i,
  input  logic               sw_trig_i,
  input  logic               ext_trig_i,
  input  logic [IN_BITS-1:0] pat_in_i,
  input  logic [IN_BITS-1:0] pat_value_i,
  input  logic [IN_BITS-1:0] pat_mask_i,
  output logic               event_o
);

  logic ext_q;
  logic match_q;
  logic match;

  assign match = ((pat_in_i ^ pat_value_i) & pat_mask_i) == '0;

  // Previous-cycle history. Match history is cleared on arm so a pattern that
  // already matches (or an all-zero mask) yields one event right after arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      ext_q   <= ext_trig_i;
      match_q <= clr_match_i ? 1'b0 : match;
    end
  end

  // Select the qualified event for the configured source.
  always_comb begin
    event_o = 1'b0;
    case (trig_src_i)
      TRIG_SW:       event_o = sw_trig_i;
      TRIG_EXT_RISE: event_o = ext_trig_i & ~ext_q;
      TRIG_EXT_FALL: event_o = ~ext_trig_i & ext_q;
      TRIG_PATTERN:  event_o = match & ~match_q;
      default:       event_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_rec_trig_ctrl.sv
// Arming/trigger sequencer that issues SEQ_EXT_START pulses to the recorder.
//
//  state   | meaning
//  IDLE    | disarmed; waits for ARM, config captured on accept
//  ARMED   | waiting for a qualified trigger event
//  DELAY   | counting shadow DELAY cycles after the event
//  FIRE    | start pulse high; count starts, decide done/holdoff/re-arm
//  HOLDOFF | counting shadow HOLDOFF cycles before re-arming
module seq_rec_trig_ctrl
  import seq_rec_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int CNT_BITS = 16
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST,
  seq_rec_trig_ctrl_if.slave bus
);

  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] count_q, count_d, count_inc;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                missed_q, missed_d;

  trig_src_e           sh_src_q, sh_src_d;
  logic [IN_BITS-1:0]  sh_pval_q, sh_pval_d;
  logic [IN_BITS-1:0]  sh_pmask_q, sh_pmask_d;
  logic [CNT_BITS-1:0] sh_delay_q, sh_delay_d;
  logic [CNT_BITS-1:0] sh_hold_q, sh_hold_d;
  logic [CNT_BITS-1:0] sh_rep_q, sh_rep_d;

  logic arm_accept;
  logic trig_event;

  seq_rec_trig_detect #(.IN_BITS(IN_BITS)) u_detect (
    .clk         (BUS_CLK),
    .rst         (BUS_RST),
    .clr_match_i (arm_accept),
    .trig_src_i  (sh_src_q),
    .sw_trig_i   (bus.SW_TRIG),
    .ext_trig_i  (bus.EXT_TRIG),
    .pat_in_i    (bus.PAT_IN),
    .pat_value_i (sh_pval_q),
    .pat_mask_i  (sh_pmask_q),
    .event_o     (trig_event)
  );

  assign count_inc = (&count_q) ? count_q : count_q + ONE;

  // Next-state, counter and shadow-register decode; ABORT overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    done_d     = done_q;
    missed_d   = missed_q;
    sh_src_d   = sh_src_q;
    sh_pval_d  = sh_pval_q;
    sh_pmask_d = sh_pmask_q;
    sh_delay_d = sh_delay_q;
    sh_hold_d  = sh_hold_q;
    sh_rep_d   = sh_rep_q;
    arm_accept = 1'b0;

    if (trig_event && (state_q == S_DELAY || state_q == S_FIRE || state_q == S_HOLDOFF))
      missed_d = 1'b1;

    if (bus.ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ARM) begin
            state_d    = S_ARMED;
            arm_accept = 1'b1;
            sh_src_d   = trig_src_e'(bus.TRIG_SRC);
            sh_pval_d  = bus.PAT_VALUE;
            sh_pmask_d = bus.PAT_MASK;
            sh_delay_d = bus.DELAY;
            sh_hold_d  = bus.HOLDOFF;
            sh_rep_d   = bus.REPEAT;
            done_d     = 1'b0;
            missed_d   = 1'b0;
            count_d    = '0;
          end
        end
        S_ARMED: begin
          if (trig_event) begin
            if (sh_delay_q == '0) begin
              state_d = S_FIRE;
            end else begin
              state_d = S_DELAY;
              cnt_d   = sh_delay_q - ONE;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) state_d = S_FIRE;
          else             cnt_d   = cnt_q - ONE;
        end
        S_FIRE: begin
          count_d = count_inc;
          if (sh_rep_q != '0 && count_inc == sh_rep_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (sh_hold_q == '0) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = sh_hold_q - ONE;
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == '0) state_d = S_ARMED;
          else             cnt_d   = cnt_q - ONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    start_d = (state_d == S_FIRE);
    busy_d  = (state_d != S_IDLE);
  end

  // All controller state and registered outputs.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      count_q    <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      missed_q   <= 1'b0;
      sh_src_q   <= TRIG_SW;
      sh_pval_q  <= '0;
      sh_pmask_q <= '0;
      sh_delay_q <= '0;
      sh_hold_q  <= '0;
      sh_rep_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      missed_q   <= missed_d;
      sh_src_q   <= sh_src_d;
      sh_pval_q  <= sh_pval_d;
      sh_pmask_q <= sh_pmask_d;
      sh_delay_q <= sh_delay_d;
      sh_hold_q  <= sh_hold_d;
      sh_rep_q   <= sh_rep_d;
    end
  end

  assign bus.SEQ_EXT_START = start_q;
  assign bus.BUSY          = busy_q;
  assign bus.DONE          = done_q;
  assign bus.MISSED        = missed_q;
  assign bus.TRIG_COUNT    = count_q;

endmodule

// File: tb/tb_seq_rec_trig_ctrl.sv
// Self-checking bench for seq_rec_trig_ctrl: vector table plus start-pulse scoreboard.
module tb_seq_rec_trig_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  seq_rec_trig_ctrl_if #(.IN_BITS(8), .CNT_BITS(16)) bus ();

  seq_rec_trig_ctrl #(.IN_BITS(8), .CNT_BITS(16)) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] delay;
    logic [7:0]  pval;
    logic [7:0]  pmask;
    logic [7:0]  pidle;
    logic [7:0]  phit;
    int          exp_lat;
    logic        exp_done;
    int          exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_arm(input logic [1:0] src, input logic [15:0] dly, input logic [15:0] hold,
                        input logic [15:0] rep, input logic [7:0] pv, input logic [7:0] pm);
    bus.TRIG_SRC  = src;
    bus.DELAY     = dly;
    bus.HOLDOFF   = hold;
    bus.REPEAT    = rep;
    bus.PAT_VALUE = pv;
    bus.PAT_MASK  = pm;
    bus.ARM       = 1'b1;
    tick();
    bus.ARM       = 1'b0;
  endtask

  task automatic do_abort();
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (!bus.BUSY) begin
        c = cyc;
        break;
      end
    end
  endtask

  // Scoreboard: every start pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (!rst && bus.SEQ_EXT_START) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL start_pulse: got cycle %0d expected cycle %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, base;

    vecs[0] = '{2'd0, 16'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b1, 1};
    vecs[1] = '{2'd0, 16'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4, 1'b1, 1};
    vecs[2] = '{2'd1, 16'd2, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1'b1, 1};
    vecs[3] = '{2'd2, 16'd1, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 1};
    vecs[4] = '{2'd1, 16'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b1, 1};
    vecs[5] = '{2'd3, 16'd2, 8'h3C, 8'hFF, 8'h00, 8'h3C, 3, 1'b1, 1};
    vecs[6] = '{2'd3, 16'd0, 8'h80, 8'h81, 8'h01, 8'hFE, 1, 1'b1, 1};

    bus.ARM = 0; bus.ABORT = 0; bus.SW_TRIG = 0; bus.EXT_TRIG = 0;
    bus.TRIG_SRC = 0; bus.PAT_IN = 0; bus.PAT_VALUE = 0; bus.PAT_MASK = 0;
    bus.DELAY = 0; bus.HOLDOFF = 0; bus.REPEAT = 0;

    // Reset state
    #23;
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_start", int'(bus.SEQ_EXT_START), 0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_busy", int'(bus.BUSY), 0);
    chk("idle_done", int'(bus.DONE), 0);
    chk("idle_missed", int'(bus.MISSED), 0);
    chk("idle_count", int'(bus.TRIG_COUNT), 0);

    // Single-shot vectors over all sources
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.EXT_TRIG = (vecs[i].src == 2'd2);
      bus.PAT_IN   = vecs[i].pidle;
      tick();
      do_arm(vecs[i].src, vecs[i].delay, 16'd0, 16'd1, vecs[i].pval, vecs[i].pmask);
      ticks(3);
      t = cyc;
      case (vecs[i].src)
        2'd0: bus.SW_TRIG = 1'b1;
        2'd1: bus.EXT_TRIG = 1'b1;
        2'd2: bus.EXT_TRIG = 1'b0;
        default: bus.PAT_IN = vecs[i].phit;
      endcase
      exp_q.push_back(t + vecs[i].exp_lat);
      tick();
      bus.SW_TRIG = 1'b0;
      wait_idle(c);
      chk($sformatf("vec%0d_busy_drop", i), c, t + vecs[i].exp_lat + 1);
      chk($sformatf("vec%0d_done", i), int'(bus.DONE), int'(vecs[i].exp_done));
      chk($sformatf("vec%0d_count", i), int'(bus.TRIG_COUNT), vecs[i].exp_count);
      chk($sformatf("vec%0d_missed", i), int'(bus.MISSED), 0);
      tick();
      bus.EXT_TRIG = 1'b0;
      bus.PAT_IN   = 8'h00;
    end

    // Rising edges at +20, +23 (missed during DELAY), +40
    tick();
    do_arm(2'd1, 16'd5, 16'd3, 16'd2, 8'h00, 8'h00);
    base = cyc;
    exp_q.push_back(base + 26);
    exp_q.push_back(base + 46);
    wait_until(base + 20); bus.EXT_TRIG = 1; tick(); bus.EXT_TRIG = 0;
    wait_until(base + 23); bus.EXT_TRIG = 1; tick(); bus.EXT_TRIG = 0;
    wait_until(base + 40); bus.EXT_TRIG = 1; tick(); bus.EXT_TRIG = 0;
    wait_idle(c);
    chk("ext_rep_busy_drop", c, base + 47);
    chk("ext_rep_missed", int'(bus.MISSED), 1);
    chk("ext_rep_done", int'(bus.DONE), 1);
    chk("ext_rep_count", int'(bus.TRIG_COUNT), 2);

    // Holdoff boundary: event on last HOLDOFF cycle missed, next cycle accepted
    tick();
    do_arm(2'd0, 16'd0, 16'd2, 16'd2, 8'h00, 8'h00);
    ticks(2);
    t = cyc;
    bus.SW_TRIG = 1; exp_q.push_back(t + 1);
    tick(); bus.SW_TRIG = 0;
    ticks(2); bus.SW_TRIG = 1;
    tick(); exp_q.push_back(t + 5);
    tick(); bus.SW_TRIG = 0;
    wait_idle(c);
    chk("hold_busy_drop", c, t + 6);
    chk("hold_missed", int'(bus.MISSED), 1);
    chk("hold_count", int'(bus.TRIG_COUNT), 2);

    // Pattern, REPEAT=0: held match fires once; re-match fires again
    tick();
    bus.PAT_IN = 8'h00;
    tick();
    do_arm(2'd3, 16'd0, 16'd0, 16'd0, 8'hA5, 8'hF0);
    ticks(2);
    t = cyc; bus.PAT_IN = 8'hA0; exp_q.push_back(t + 1);
    ticks(10);
    bus.PAT_IN = 8'h00;
    ticks(3);
    t = cyc; bus.PAT_IN = 8'hAF; exp_q.push_back(t + 1);
    ticks(4);
    @(negedge clk);
    chk("pat_busy", int'(bus.BUSY), 1);
    chk("pat_done", int'(bus.DONE), 0);
    chk("pat_count", int'(bus.TRIG_COUNT), 2);
    tick();
    do_abort();
    @(negedge clk);
    chk("pat_abort_busy", int'(bus.BUSY), 0);
    chk("pat_abort_done", int'(bus.DONE), 0);
    chk("pat_abort_count", int'(bus.TRIG_COUNT), 2);

    // Zero mask: one event right after arm, then nothing
    tick();
    do_arm(2'd3, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00);
    exp_q.push_back(cyc + 1);
    ticks(10);
    do_abort();
    @(negedge clk);
    chk("mask0_count", int'(bus.TRIG_COUNT), 1);
    bus.PAT_IN = 8'h00;

    // Falling edge, DELAY=4, ABORT on the cycle before FIRE
    tick();
    bus.EXT_TRIG = 1'b1;
    tick();
    do_arm(2'd2, 16'd4, 16'd0, 16'd1, 8'h00, 8'h00);
    ticks(2);
    t = cyc; bus.EXT_TRIG = 1'b0;
    ticks(4);
    do_abort();
    @(negedge clk);
    chk("fall_abort_busy", int'(bus.BUSY), 0);
    chk("fall_abort_done", int'(bus.DONE), 0);
    chk("fall_abort_count", int'(bus.TRIG_COUNT), 0);
    ticks(8);

    // ARM and ABORT together in IDLE
    bus.ARM = 1; bus.ABORT = 1;
    tick();
    bus.ARM = 0; bus.ABORT = 0;
    @(negedge clk);
    chk("arm_abort_busy0", int'(bus.BUSY), 0);
    tick();
    @(negedge clk);
    chk("arm_abort_busy1", int'(bus.BUSY), 0);

    // Re-ARM while ARMED is ignored: old shadow DELAY=2 stays
    tick();
    do_arm(2'd0, 16'd2, 16'd0, 16'd1, 8'h00, 8'h00);
    ticks(2);
    bus.DELAY = 16'd7; bus.ARM = 1;
    tick();
    bus.ARM = 0;
    tick();
    t = cyc; bus.SW_TRIG = 1; exp_q.push_back(t + 3);
    tick(); bus.SW_TRIG = 0;
    wait_idle(c);
    chk("shadow_busy_drop", c, t + 4);
    chk("shadow_count", int'(bus.TRIG_COUNT), 1);

    // Asynchronous reset in the middle of DELAY
    tick();
    do_arm(2'd0, 16'd6, 16'd0, 16'd1, 8'h00, 8'h00);
    ticks(2);
    bus.SW_TRIG = 1;
    tick(); bus.SW_TRIG = 0;
    ticks(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(bus.BUSY), 0);
    chk("async_rst_start", int'(bus.SEQ_EXT_START), 0);
    chk("async_rst_done", int'(bus.DONE), 0);
    chk("async_rst_missed", int'(bus.MISSED), 0);
    chk("async_rst_count", int'(bus.TRIG_COUNT), 0);
    #10 rst = 1'b0;
    ticks(12);
    @(negedge clk);
    chk("post_rst_busy", int'(bus.BUSY), 0);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rec_trig_ctrl.md
Name: seq_rec_trig_ctrl

Overview:
Trigger/arming controller that sequences the sequence recorder by generating its SEQ_EXT_START pulse.
- Software arms it, selects a trigger source, then it waits for a qualified event.
- On each event it applies a programmable delay, fires one start pulse, waits a hold-off, and re-arms until REPEAT starts have been issued.
- Sits in the BUS_CLK domain between the register file and the recorder's external start input.

Parameters:
IN_BITS, 8, width of monitored pattern bus
CNT_BITS, 16, width of DELAY/HOLDOFF/REPEAT/TRIG_COUNT

Ports:
BUS_CLK  input  1  single clock for all logic
BUS_RST  input  1  asynchronous, active-high reset
ARM  input  1  one-cycle pulse; arms controller when IDLE
ABORT  input  1  one-cycle pulse; returns to IDLE from any state
SW_TRIG  input  1  software trigger pulse (source 0)
EXT_TRIG  input  1  external trigger, already synchronous to BUS_CLK
TRIG_SRC  input  2  0=SW, 1=EXT rising, 2=EXT falling, 3=pattern match
PAT_IN  input  IN_BITS  monitored signals for pattern trigger
PAT_VALUE  input  IN_BITS  pattern compare value
PAT_MASK  input  IN_BITS  1=bit participates in compare
DELAY  input  CNT_BITS  cycles between event and start pulse
HOLDOFF  input  CNT_BITS  cycles after start pulse before re-arm
REPEAT  input  CNT_BITS  starts per arm; 0=infinite
SEQ_EXT_START  output  1  one-cycle start pulse to recorder
BUSY  output  1  state != IDLE
DONE  output  1  sticky; REPEAT starts completed
MISSED  output  1  sticky; event seen while in DELAY/HOLDOFF
TRIG_COUNT  output  CNT_BITS  starts issued since last ARM, saturating

Behaviour:
- Reset (async, BUS_RST=1):
  - State=IDLE.
  - SEQ_EXT_START, BUSY, DONE, MISSED = 0; TRIG_COUNT = 0.
  - Edge/pattern history registers = 0.
- Config shadowing: TRIG_SRC, PAT_VALUE, PAT_MASK, DELAY, HOLDOFF and REPEAT are captured into shadow registers on an accepted ARM. Later input changes have no effect until the next ARM.
- Event detection, evaluated every cycle; `ext_d` and `match_d` are registered copies of the previous cycle:
  - src0: SW_TRIG.
  - src1: EXT_TRIG & ~ext_d.
  - src2: ~EXT_TRIG & ext_d.
  - src3: match & ~match_d, where match = ((PAT_IN ^ PAT_VALUE) & PAT_MASK)==0. A held match fires once. PAT_MASK=0 gives match=1 constantly, so one event after arm and none after.
- States: IDLE, ARMED, DELAY, FIRE, HOLDOFF.
- IDLE:
  - ARM -> ARMED; clears DONE, MISSED, TRIG_COUNT.
  - ARM in any other state is ignored.
- ARMED: event in cycle t -> FIRE if shadow DELAY==0, else DELAY.
- Start latency: SEQ_EXT_START is high in cycle t+1+DELAY, exactly one cycle.
- DELAY: counts DELAY cycles, then -> FIRE.
- FIRE (SEQ_EXT_START=1, TRIG_COUNT+1 saturating at all-ones):
  - If REPEAT!=0 and new count == REPEAT -> IDLE with DONE=1.
  - Else if HOLDOFF==0 -> ARMED.
  - Else -> HOLDOFF.
- HOLDOFF: counts HOLDOFF cycles, then -> ARMED. With HOLDOFF=H, the earliest accepted next event is H+1 cycles after the FIRE cycle.
- MISSED: an event in DELAY, FIRE or HOLDOFF sets MISSED and is dropped; it is never queued.
- ABORT: highest priority; state -> IDLE on the next edge.
  - An ABORT coincident with the FIRE-entry cycle suppresses the pulse.
  - DONE is not set; TRIG_COUNT and MISSED are kept for readback.
- ABORT and ARM in the same IDLE cycle: ABORT wins, stays IDLE.
- REPEAT=0: runs until ABORT; DONE never set.
- BUSY is registered and equals (next_state != IDLE), i.e. BUSY rises the cycle after ARM.

Decomposition:
- Shared package seq_rec_pkg holds:
  - TRIG_SRC encodings (TRIG_SW, TRIG_EXT_RISE, TRIG_EXT_FALL, TRIG_PATTERN).
  - State encoding localparams.
- Sub-module seq_rec_trig_detect holds the edge/pattern history registers and source mux, and outputs the single-cycle `event`.
- The FSM, counters and shadow registers stay in the top.

Test Plan:
- Reset mid-DELAY (assert BUS_RST for 1 cycle asynchronously) -> all outputs 0 immediately; no start pulse afterward.
- SRC=0, DELAY=0, REPEAT=1; ARM, then SW_TRIG at cycle 10 -> SEQ_EXT_START high only at cycle 11, DONE=1, TRIG_COUNT=1, BUSY=0 at cycle 12.
- SRC=1, DELAY=5, HOLDOFF=3, REPEAT=2; EXT rises at cycles 20, 23, 40 -> starts at 26 and 46; MISSED=1 (event 23 during DELAY); DONE=1, TRIG_COUNT=2.
- SRC=3, PAT_VALUE=0xA5, PAT_MASK=0xF0, REPEAT=0; PAT_IN=0xA0 held 10 cycles, then 0x00, then 0xAF -> exactly 2 starts; BUSY stays 1; ABORT -> IDLE, DONE=0.
- SRC=2, DELAY=4; falling edge at t, ABORT at t+4 -> no SEQ_EXT_START, state IDLE.
- In IDLE, ARM+ABORT same cycle -> BUSY stays 0; ARM during ARMED with new DELAY -> old shadow DELAY still used.
